// File: rtl/imgproc_target_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imgproc_target_sched                                       |
// | Description : Round-robin colour-target scheduler. Programs a colour     |
// |               into the image processor, drains settle messages, then     |
// |               stores the XY/distance result per slot, with timeout.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module imgproc_target_sched #(
  parameter int unsigned SETTLE_MSGS    = 1,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_chipselect,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [2:0]  s_address,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  localparam logic [31:0] C_ID     = 32'h1234EEE3;
  localparam logic [31:0] C_MAGIC  = 32'h00524242;
  localparam logic [7:0]  C_SETTLE = 8'(SETTLE_MSGS);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    NEXT     = 4'd1,
    WR_COL   = 4'd2,
    WR_FLUSH = 4'd3,
    POLL     = 4'd4,
    POLL_CAP = 4'd5,
    RD_MSG   = 4'd6,
    RD_CAP   = 4'd7,
    GAP      = 4'd8,
    STORE    = 4'd9
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_enable, r_started, r_resync;
  logic [3:0]  r_mask;
  logic [1:0]  r_rsel, r_slot, r_word;
  logic [7:0]  r_disc;
  logic [23:0] r_tmr;
  logic [21:0] r_w1_xy;
  logic [18:0] r_w2_dist;
  logic [23:0] r_colour [4];
  logic [21:0] r_xy     [4];
  logic [18:0] r_dist   [4];
  logic [7:0]  r_cnt    [4];
  logic [3:0]  r_valid, r_tmo;
  logic [31:0] r_readdata;

  logic        w_found, w_tmo_hit, w_do_tmo, w_busy, w_counting;
  logic [1:0]  w_found_slot;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_unused   = &{1'b0, s_writedata[31:24]};
  assign w_busy     = (r_state != IDLE);
  assign w_tmo_hit  = (r_tmr >= TIMEOUT_CYCLES);
  assign w_counting = (r_state == POLL) || (r_state == POLL_CAP) || (r_state == RD_MSG) ||
                      (r_state == RD_CAP) || (r_state == GAP);
  assign s_readdata = r_readdata;

  // Master strobes decode straight from the state so a reset to IDLE silences them at once
  always_comb begin
    m_read       = (r_state == POLL) || (r_state == RD_MSG);
    m_write      = (r_state == WR_COL) || (r_state == WR_FLUSH);
    m_chipselect = m_read | m_write;
    m_address    = 3'd0;
    m_writedata  = 32'h0;
    case (r_state)
      WR_COL:   begin m_address = 3'd3; m_writedata = {8'h0, r_colour[r_slot]}; end
      WR_FLUSH: m_writedata = 32'h10;
      RD_MSG:   m_address = 3'd1;
      default:  ;
    endcase
  end

  // Round-robin pick: first enabled slot after the current one (from slot 0 until the first pick)
  always_comb begin
    logic [1:0] cand;
    w_found      = 1'b0;
    w_found_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = r_started ? (r_slot + 2'd1 + 2'(i)) : 2'(i);
      if (r_mask[cand]) begin
        w_found      = 1'b1;
        w_found_slot = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; disable wins over timeout so a disabled run leaves results untouched
  always_comb begin
    w_state_nxt = r_state;
    w_do_tmo    = 1'b0;
    case (r_state)
      IDLE:     if (r_enable) w_state_nxt = NEXT;
      NEXT:     if (!r_enable) w_state_nxt = IDLE;
                else if (w_found) w_state_nxt = WR_COL;
      WR_COL:   w_state_nxt = r_enable ? WR_FLUSH : IDLE;
      WR_FLUSH: w_state_nxt = r_enable ? POLL : IDLE;
      POLL:     w_state_nxt = POLL_CAP;
      RD_MSG:   w_state_nxt = RD_CAP;
      POLL_CAP: begin
        if (!r_enable) w_state_nxt = IDLE;
        else if (w_tmo_hit) begin w_state_nxt = NEXT; w_do_tmo = 1'b1; end
        else if (m_readdata[15:8] >= 8'd3) w_state_nxt = RD_MSG;
        else w_state_nxt = GAP;
      end
      RD_CAP: begin
        if (!r_enable) w_state_nxt = IDLE;
        else if (w_tmo_hit) begin w_state_nxt = NEXT; w_do_tmo = 1'b1; end
        else if (r_word == 2'd0) w_state_nxt = (m_readdata != C_MAGIC) ? WR_FLUSH : GAP;
        else if (r_word == 2'd1) w_state_nxt = GAP;
        else w_state_nxt = (r_disc < C_SETTLE) ? POLL : STORE;
      end
      GAP: begin
        if (!r_enable) w_state_nxt = IDLE;
        else if (w_tmo_hit) begin w_state_nxt = NEXT; w_do_tmo = 1'b1; end
        else w_state_nxt = (r_word == 2'd0) ? POLL : RD_MSG;
      end
      STORE:    w_state_nxt = r_enable ? NEXT : IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // CPU register read mux
  always_comb begin
    w_rd_mux = 32'h0;
    case (s_address)
      3'd0: w_rd_mux = {15'h0, w_busy, 2'b0, r_rsel, 2'b0, r_slot, r_mask, 3'b0, r_enable};
      3'd1: w_rd_mux = {8'h0, r_colour[0]};
      3'd2: w_rd_mux = {8'h0, r_colour[1]};
      3'd3: w_rd_mux = {8'h0, r_colour[2]};
      3'd4: w_rd_mux = {8'h0, r_colour[3]};
      3'd5: w_rd_mux = {5'b0, r_xy[r_rsel][21:11], 5'b0, r_xy[r_rsel][10:0]};
      3'd6: w_rd_mux = {r_valid[r_rsel], r_tmo[r_rsel], 2'b0, r_cnt[r_rsel], 1'b0, r_dist[r_rsel]};
      default: w_rd_mux = C_ID;
    endcase
  end

  // CPU registers, message capture, counters and per-slot results
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_mask     <= 4'h0;
      r_rsel     <= 2'd0;
      r_slot     <= 2'd0;
      r_started  <= 1'b0;
      r_resync   <= 1'b0;
      r_word     <= 2'd0;
      r_disc     <= 8'd0;
      r_tmr      <= 24'd0;
      r_w1_xy    <= 22'd0;
      r_w2_dist  <= 19'd0;
      r_valid    <= 4'h0;
      r_tmo      <= 4'h0;
      r_readdata <= 32'h0;
      for (int i = 0; i < 4; i++) begin
        r_colour[i] <= 24'h0;
        r_xy[i]     <= 22'h0;
        r_dist[i]   <= 19'h0;
        r_cnt[i]    <= 8'h0;
      end
    end else begin
      if (s_chipselect && s_write) begin
        case (s_address)
          3'd0: begin
            r_enable <= s_writedata[0];
            r_mask   <= s_writedata[7:4];
            r_rsel   <= s_writedata[13:12];
          end
          3'd1: r_colour[0] <= s_writedata[23:0];
          3'd2: r_colour[1] <= s_writedata[23:0];
          3'd3: r_colour[2] <= s_writedata[23:0];
          3'd4: r_colour[3] <= s_writedata[23:0];
          default: ;
        endcase
      end
      if (s_chipselect && s_read) r_readdata <= w_rd_mux;

      if (w_counting && !w_tmo_hit) r_tmr <= r_tmr + 24'd1;

      case (r_state)
        NEXT: if (r_enable && w_found) begin
          r_slot    <= w_found_slot;
          r_started <= 1'b1;
        end
        // A resync re-flushes but keeps the settle progress and the per-slot time budget
        WR_FLUSH: begin
          r_word   <= 2'd0;
          r_resync <= 1'b0;
          if (!r_resync) begin
            r_disc <= 8'd0;
            r_tmr  <= 24'd0;
          end
        end
        RD_CAP: begin
          if (w_state_nxt == WR_FLUSH) r_resync <= 1'b1;
          if (w_state_nxt == GAP) r_word <= r_word + 2'd1;
          if (r_word == 2'd1) r_w1_xy <= {m_readdata[26:16], m_readdata[10:0]};
          if (r_word == 2'd2) r_w2_dist <= m_readdata[18:0];
          if (w_state_nxt == POLL) begin
            r_disc <= r_disc + 8'd1;
            r_word <= 2'd0;
          end
        end
        STORE: if (r_enable) begin
          r_xy[r_slot]    <= r_w1_xy;
          r_dist[r_slot]  <= r_w2_dist;
          r_valid[r_slot] <= 1'b1;
          r_tmo[r_slot]   <= 1'b0;
          r_cnt[r_slot]   <= r_cnt[r_slot] + 8'd1;
        end
        default: ;
      endcase

      if (w_do_tmo) begin
        r_valid[r_slot] <= 1'b0;
        r_tmo[r_slot]   <= 1'b1;
        r_cnt[r_slot]   <= r_cnt[r_slot] + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imgproc_target_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_imgproc_target_sched                                    |
// | Description : Directed self-checking bench with a small image-processor  |
// |               slave model and a write logger.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_imgproc_target_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [2:0]  s_address = 3'd0;
  logic [31:0] s_writedata = 32'h0;
  logic [31:0] s_readdata;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sl_status = 32'h0;
  logic [31:0] sl_words[$];
  int          rd1_cnt = 0;
  logic [2:0]  wa [64];
  logic [31:0] wd [64];
  int          wn = 0;
  logic        prev_read = 1'b0;
  logic [31:0] rd;

  imgproc_target_sched #(.SETTLE_MSGS(1), .TIMEOUT_CYCLES(24'd100)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_chipselect(s_chipselect), .s_read(s_read), .s_write(s_write),
    .s_address(s_address), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Slave model: read data valid the cycle after m_read; log every write
  always @(posedge clk) begin
    if (m_read) begin
      if (m_address == 3'd0) m_readdata <= sl_status;
      else begin
        rd1_cnt++;
        if (sl_words.size() > 0) m_readdata <= sl_words.pop_front();
        else m_readdata <= 32'h0;
      end
    end
    if (m_write && wn < 64) begin
      wa[wn] = m_address;
      wd[wn] = m_writedata;
      wn++;
    end
  end

  // Bus rules: cs = rd|wr, never rd&wr, never two reads back to back
  always @(negedge clk) begin
    if (reset_n) begin
      n_cmp++;
      assert (m_chipselect === (m_read | m_write) && !(m_read && m_write) && !(m_read && prev_read))
      else begin
        n_bad++;
        $error("FAIL bus_rules cs=%b rd=%b wr=%b prev_rd=%b", m_chipselect, m_read, m_write, prev_read);
      end
    end
    prev_read = m_read;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [31:0] d);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    @(negedge clk);
    s_chipselect = 1'b0; s_read = 1'b0;
    d = s_readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_chipselect = 1'b0; s_read = 1'b0; s_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sl_words.delete();
    sl_status = 32'h0;
    wn = 0;
    rd1_cnt = 0;
    reset_n = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (wn < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (wn >= n) else begin
      n_bad++;
      $error("FAIL %s writes_seen=%0d required=%0d", tag, wn, n);
    end
  endtask

  task automatic wait_read(input logic [2:0] a, input int budget, input string tag);
    int k = 0;
    while (!(m_read && m_address == a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    assert (m_read && m_address == a) else begin
      n_bad++;
      $error("FAIL %s read_addr%0d_seen=0 required=1", tag, a);
    end
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state and register map
    check("rst_m_ctl", {29'h0, m_chipselect, m_read, m_write}, 32'h0);
    check("rst_m_addr_data", m_writedata | {29'h0, m_address}, 32'h0);
    cpu_rd(3'd0, rd); check("rst_ctrl", rd, 32'h0);
    cpu_rd(3'd7, rd); check("id", rd, 32'h1234EEE3);
    cpu_rd(3'd6, rd); check("rst_dist", rd, 32'h0);
    cpu_wr(3'd3, 32'hABCDEF12);
    cpu_rd(3'd3, rd); check("colour2_rb", rd, 32'h00CDEF12);

    // Enabled with empty mask: busy in NEXT, no master traffic
    cpu_wr(3'd0, 32'h1);
    repeat (10) @(negedge clk);
    check("mask0_no_writes", 32'(wn), 32'd0);
    cpu_rd(3'd0, rd); check("mask0_ctrl", rd, 32'h00010001);

    // Settle + store on slot 1
    do_reset();
    cpu_wr(3'd2, 32'h00FF00FF);
    sl_status = 32'h300;
    sl_words = '{32'h00524242, 32'h00640032, 32'h000003E8,
                 32'h00524242, 32'h00640032, 32'h000003E8};
    cpu_wr(3'd0, 32'h21);
    wait_writes(3, 200, "store_revisit");
    sl_status = 32'h0;
    cpu_wr(3'd0, 32'h1020);
    repeat (4) @(negedge clk);
    check("store_wr0_addr", {29'h0, wa[0]}, 32'd3);
    check("store_wr0_data", wd[0], 32'h00FF00FF);
    check("store_wr1_addr", {29'h0, wa[1]}, 32'd0);
    check("store_wr1_data", wd[1], 32'h10);
    check("store_two_msgs_read", 32'(rd1_cnt), 32'd6);
    cpu_rd(3'd5, rd); check("store_res_xy", rd, 32'h00640032);
    cpu_rd(3'd6, rd); check("store_res_dist", rd, 32'h801003E8);
    cpu_rd(3'd0, rd); check("store_ctrl", rd, 32'h00001120);

    // Round-robin over mask 1011: slots 0,1,3,0
    do_reset();
    cpu_wr(3'd1, 32'hA);
    cpu_wr(3'd2, 32'hB);
    cpu_wr(3'd3, 32'hC);
    cpu_wr(3'd4, 32'hD);
    cpu_wr(3'd0, 32'hB1);
    wait_writes(8, 800, "rr_visits");
    cpu_wr(3'd0, 32'h0);
    check("rr_v0", {wa[0], wd[0][28:0]}, {3'd3, 29'hA});
    check("rr_v1", {wa[2], wd[2][28:0]}, {3'd3, 29'hB});
    check("rr_v2", {wa[4], wd[4][28:0]}, {3'd3, 29'hD});
    check("rr_v3", {wa[6], wd[6][28:0]}, {3'd3, 29'hA});

    // Bad header: flush reissued, nothing stored
    do_reset();
    sl_status = 32'h300;
    sl_words = '{32'hDEADBEEF};
    cpu_wr(3'd0, 32'h11);
    repeat (30) @(negedge clk);
    cpu_wr(3'd0, 32'h0);
    repeat (4) @(negedge clk);
    check("resync_wr2", {wa[2], wd[2][28:0]}, {3'd0, 29'h10});
    cpu_rd(3'd6, rd); check("resync_no_store", rd, 32'h0);

    // Timeout on slot 0, then slot 1 begins
    do_reset();
    cpu_wr(3'd1, 32'h11);
    cpu_wr(3'd2, 32'h22);
    cpu_wr(3'd0, 32'h31);
    wait_writes(3, 400, "tmo_next_slot");
    cpu_wr(3'd0, 32'h30);
    repeat (4) @(negedge clk);
    check("tmo_next_colour", {wa[2], wd[2][28:0]}, {3'd3, 29'h22});
    cpu_rd(3'd6, rd); check("tmo_res_dist", rd, 32'h40100000);
    cpu_rd(3'd5, rd); check("tmo_res_xy", rd, 32'h0);

    // Disable during RD_CAP
    do_reset();
    sl_status = 32'h300;
    sl_words = '{32'h00524242, 32'h00640032, 32'h000003E8};
    cpu_wr(3'd0, 32'h11);
    wait_read(3'd1, 100, "dis_rdmsg");
    @(negedge clk);
    cpu_wr(3'd0, 32'h0);
    @(negedge clk);
    cpu_rd(3'd0, rd); check("dis_ctrl_idle", rd, 32'h0);
    cpu_rd(3'd5, rd); check("dis_res_xy", rd, 32'h0);
    cpu_rd(3'd6, rd); check("dis_res_dist", rd, 32'h0);

    // Reset in the middle of POLL
    do_reset();
    cpu_wr(3'd0, 32'h11);
    wait_read(3'd0, 50, "rst_poll");
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_m_ctl", {29'h0, m_chipselect, m_read, m_write}, 32'h0);
    check("midrst_m_addr_data", m_writedata | {29'h0, m_address}, 32'h0);
    reset_n = 1'b1;
    cpu_rd(3'd0, rd); check("midrst_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imgproc_target_sched.md
IMGPROC_TARGET_SCHED -- requirements
Module: imgproc_target_sched

Interface
REQ-001 SHALL have parameter SETTLE_MSGS, default 1, giving the number of complete messages discarded after each colour change before a result is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd5000000, giving the cycle limit per slot for obtaining an accepted message.
REQ-003 SHALL have port clk, input, 1, single clock; every register SHALL be clocked on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port s_chipselect, input, 1, CPU slave select.
REQ-006 SHALL have port s_read, input, 1, CPU read strobe.
REQ-007 SHALL have port s_write, input, 1, CPU write strobe.
REQ-008 SHALL have port s_address, input, 3, CPU register address.
REQ-009 SHALL have port s_writedata, input, 32, CPU write data.
REQ-010 SHALL have port s_readdata, output, 32, CPU read data, registered, valid the cycle after s_read.
REQ-011 SHALL have port m_chipselect, output, 1, image-processor slave select.
REQ-012 SHALL have port m_read, output, 1, image-processor read strobe.
REQ-013 SHALL have port m_write, output, 1, image-processor write strobe.
REQ-014 SHALL have port m_address, output, 3, image-processor address.
REQ-015 SHALL have port m_writedata, output, 32, image-processor write data.
REQ-016 SHALL have port m_readdata, input, 32, image-processor read data, valid one cycle after m_read.

Function
REQ-017 SHALL decode CPU registers as follows: 0 CTRL, with bit0 enable, bits7:4 slot mask, bits13:12 result select (rsel) read/write, bits9:8 current slot read-only, bit16 busy read-only; 1-4 COLOUR slot0-3, bits23:0; 5 RES_XY[rsel]; 6 RES_DIST[rsel]; 7 ID, reading 32'h1234EEE3.
REQ-018 SHALL encode RES_XY as {5'b0,x[10:0],5'b0,y[10:0]}, and RES_DIST as bit31 valid, bit30 timeout, bits27:20 update count (wraps at 255), bits18:0 distance.
REQ-019 SHALL use FSM states IDLE, NEXT, WR_COL, WR_FLUSH, POLL, POLL_CAP, RD_MSG, RD_CAP, GAP and STORE.
REQ-020 SHALL, in NEXT, select the next slot set in the mask, round-robin after the current slot with wrap 3->0; SHALL, from reset, start the search at slot 0; SHALL stay in NEXT with no master traffic while the mask is 0.
REQ-021 SHALL, in WR_COL, issue a one-cycle write of {8'h0,COLOUR[slot]} to address 3, then in WR_FLUSH a one-cycle write of 32'h10 to address 0, and clear the word counter, discard counter and timeout counter.
REQ-022 SHALL, in POLL, issue a one-cycle read of address 0, capture it in POLL_CAP, and go to RD_MSG if bits15:8 >= 3, else to GAP then back to POLL.
REQ-023 SHALL, in RD_MSG, issue a one-cycle read of address 1, capture it in RD_CAP as word 0, 1 or 2, then pass through GAP; m_read SHALL never be high on two consecutive cycles.
REQ-024 SHALL treat word 0 not equal to 32'h00524242 as a resync: return to WR_FLUSH with the discard counter unchanged.
REQ-025 SHALL, after word 2, increment the discard counter if it is below SETTLE_MSGS and return to POLL; otherwise go to STORE.
REQ-026 SHALL, in STORE, write XY from word 1 and distance from word2[18:0] into the slot, set valid=1 and timeout=0, increment the update count, then go to NEXT.
REQ-027 SHALL, when the timeout counter reaches TIMEOUT_CYCLES in any state from POLL to GAP, set the slot's valid=0 and timeout=1, keep its XY and distance, increment its update count, and go to NEXT once no master strobe is pending.
REQ-028 SHALL, on enable going to 0, complete any in-flight read or capture, store nothing, and enter IDLE; SHALL leave IDLE for NEXT when enable=1.
REQ-029 SHALL apply a COLOUR write to the active slot on that slot's next visit, and never re-issue the colour mid-visit.
REQ-030 SHALL drive m_chipselect equal to m_read|m_write, and m_write and m_read SHALL never be high together.
REQ-031 SHALL report busy = (state != IDLE).

Reset
REQ-032 SHALL, while reset_n=0 at a clock edge, set state to IDLE and clear CTRL, COLOUR[0-3], all results, all counters, current slot, s_readdata and every m_* output to 0.
REQ-033 SHALL, on reset mid-transaction, deassert all m_* outputs on the next cycle and discard any partial message.

Verification
REQ-034 SHALL cover: COLOUR1=24'hFF00FF, CTRL=32'h21, slave returns status 32'h300 then words 32'h524242, 32'h00640032, 32'h3E8 twice -> write of addr3 with 32'hFF00FF, write of addr0 with 32'h10, first message discarded; with rsel=1, RES_XY=32'h00640032 and RES_DIST=32'h801003E8.
REQ-035 SHALL cover: mask 4'b1011 -> colour writes visit slots 0,1,3,0 in that order.
REQ-036 SHALL cover: word0=32'hDEADBEEF -> addr0 write of 32'h10 reissued and no STORE.
REQ-037 SHALL cover: status stuck at 0 with TIMEOUT_CYCLES=100 -> RES_DIST bit30=1, bit31=0, update count 1, then next slot begins.
REQ-038 SHALL cover: enable cleared during RD_CAP -> busy=0 within 3 cycles and results unchanged.
REQ-039 SHALL cover: reset_n=0 mid-POLL -> next cycle all m_* outputs are 0, and a CTRL read returns 0.
